// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA raster generator (800x600@60 Hz, 40 MHz pixel clock).
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic bit cnt_fits(input int v);
    return (v >= 0) && (v < (1 << CNT_W));
  endfunction

endpackage

// File: rtl/vga_if_tim.sv
// Raster timing bundle: producer drives through out, draw stages sample through in.
interface vga_if_tim;
  import vga_pkg::*;

  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;

  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk);
  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk);

endinterface

// File: rtl/vga_axis_tim.sv
// One raster axis: next count plus sync/blank flags derived from that next count.
module vga_axis_tim
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b1
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             step_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             sync_o,
  output logic             blnk_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] ACT_C  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_S = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_E = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

  logic last;

  assign last   = (cnt_i == LAST);
  assign wrap_o = step_i & last;

  always_comb begin
    cnt_nxt_o = cnt_i;
    if (clear_i) begin
      cnt_nxt_o = '0;
    end else if (step_i) begin
      cnt_nxt_o = last ? '0 : cnt_i + CNT_W'(1);
    end
  end

  // Flags follow the count that will be registered, so they never lag it.
  assign blnk_o = (cnt_nxt_o >= ACT_C);
  assign sync_o = ((cnt_nxt_o >= SYNC_S) && (cnt_nxt_o < SYNC_E)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator with pixel enable and frame-start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      pix_en,
  vga_if_tim.out    tim,
  output logic      frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!cnt_fits(H_TOTAL - 1) || !cnt_fits(V_TOTAL - 1)) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit the 11-bit counters");
  end

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             fs_q, fs_d;
  logic             h_wrap, v_wrap, v_step;

  assign v_step = pix_en & h_wrap;

  vga_axis_tim #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HSYNC_POL)
  ) u_h (
    .cnt_i     (hcount_q),
    .step_i    (pix_en),
    .clear_i   (~rst_n),
    .cnt_nxt_o (hcount_d),
    .sync_o    (hsync_d),
    .blnk_o    (hblnk_d),
    .wrap_o    (h_wrap)
  );

  vga_axis_tim #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VSYNC_POL)
  ) u_v (
    .cnt_i     (vcount_q),
    .step_i    (v_step),
    .clear_i   (~rst_n),
    .cnt_nxt_o (vcount_d),
    .sync_o    (vsync_d),
    .blnk_o    (vblnk_d),
    .wrap_o    (v_wrap)
  );

  // Pulse only on the real last-pixel wrap; reset exit lands on (0,0) silently.
  assign fs_d = v_step & v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
    end
  end

  assign tim.hcount  = hcount_q;
  assign tim.vcount  = vcount_q;
  assign tim.hsync   = hsync_q;
  assign tim.vsync   = vsync_q;
  assign tim.hblnk   = hblnk_q;
  assign tim.vblnk   = vblnk_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing, reduced-timing and inverted-polarity instances against a pixel-index model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b1;
  logic fs_a, fs_b, fs_c;

  vga_if_tim if_a ();
  vga_if_tim if_b ();
  vga_if_tim if_c ();

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .tim (if_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
  ) u_sml (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .tim (if_b), .frame_start (fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) u_neg (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .tim (if_c), .frame_start (fs_c)
  );

  // Model: each instance is a linear pixel index within its frame.
  int HA[3] = '{800, S_HA, S_HA};
  int HF[3] = '{40,  S_HF, S_HF};
  int HS[3] = '{128, S_HS, S_HS};
  int HB[3] = '{88,  S_HB, S_HB};
  int VA[3] = '{600, S_VA, S_VA};
  int VF[3] = '{1,   S_VF, S_VF};
  int VS[3] = '{4,   S_VS, S_VS};
  int VB[3] = '{23,  S_VB, S_VB};
  int HP[3] = '{1, 1, 0};
  int VP[3] = '{1, 1, 0};
  int pos[3] = '{0, 0, 0};
  int fsm[3] = '{0, 0, 0};

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit meas = 1'b0;
  int exp_period = 0, last_fs = -1, n_fs = 0;
  bit cnt_hs = 1'b0;
  int hs_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_inst(input int k, input int hc, input int vc, input int hs,
                            input int vs, input int hb, input int vb, input int fs);
    int ht, h, v, e_hs, e_vs;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    h = pos[k] % ht;
    v = pos[k] / ht;
    e_hs = (h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]) ? HP[k] : 1 - HP[k];
    e_vs = (v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]) ? VP[k] : 1 - VP[k];
    check($sformatf("i%0d hcount c%0d", k, cyc), hc, h);
    check($sformatf("i%0d vcount c%0d", k, cyc), vc, v);
    check($sformatf("i%0d hsync c%0d", k, cyc), hs, e_hs);
    check($sformatf("i%0d vsync c%0d", k, cyc), vs, e_vs);
    check($sformatf("i%0d hblnk c%0d", k, cyc), hb, int'(h >= HA[k]));
    check($sformatf("i%0d vblnk c%0d", k, cyc), vb, int'(v >= VA[k]));
    check($sformatf("i%0d frame_start c%0d", k, cyc), fs, fsm[k]);
  endtask

  task automatic step(input logic r, input logic e);
    int tot;
    rst_n  = r;
    pix_en = e;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      tot = (HA[k] + HF[k] + HS[k] + HB[k]) * (VA[k] + VF[k] + VS[k] + VB[k]);
      if (!r) begin
        pos[k] = 0;
        fsm[k] = 0;
      end else if (e) begin
        pos[k] = (pos[k] + 1) % tot;
        fsm[k] = int'(pos[k] == 0);
      end else begin
        fsm[k] = 0;
      end
    end
    #1;
    check_inst(0, if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync, if_a.hblnk, if_a.vblnk, fs_a);
    check_inst(1, if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync, if_b.hblnk, if_b.vblnk, fs_b);
    check_inst(2, if_c.hcount, if_c.vcount, if_c.hsync, if_c.vsync, if_c.hblnk, if_c.vblnk, fs_c);
    if (meas && fs_b) begin
      if (last_fs >= 0) check("frame_period", cyc - last_fs, exp_period);
      last_fs = cyc;
      n_fs++;
    end
    if (cnt_hs && if_a.vcount == 0 && if_a.hsync) hs_cnt++;
  endtask

  initial begin
    // Reset held with pix_en high.
    repeat (3) step(1'b0, 1'b1);
    check("rst hcount", if_a.hcount, 0);
    check("rst vcount", if_a.vcount, 0);
    check("rst hblnk", if_a.hblnk, 0);
    check("rst vblnk", if_a.vblnk, 0);
    check("rst hsync", if_a.hsync, 0);
    check("rst vsync", if_a.vsync, 0);
    check("rst frame_start", fs_a, 0);
    check("rst neg hsync", if_c.hsync, 1);
    check("rst neg vsync", if_c.vsync, 1);

    // Free run: two reduced frames and the first full default line.
    meas = 1'b1; exp_period = 31 * 16; last_fs = -1; n_fs = 0;
    cnt_hs = 1'b1; hs_cnt = 0;
    repeat (1200) step(1'b1, 1'b1);
    cnt_hs = 1'b0;
    check("fs_count_run", n_fs, 2);
    check("line0_hsync_len", hs_cnt, 128);

    // Alternate pix_en: frame period doubles.
    last_fs = -1; n_fs = 0; exp_period = 2 * 31 * 16;
    for (int i = 0; i < 2400; i++) step(1'b1, (i % 2) == 0);
    check("fs_count_gated", n_fs, 2);
    meas = 1'b0;

    // Random enable with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1);

    // Mid-frame reset on the reduced instance at (10,7).
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 1200 && !hit; i++) begin
        step(1'b1, 1'b1);
        if (pos[1] == 7 * 31 + 10) hit = 1'b1;
      end
      check("reach_mid_frame", int'(hit), 1);
    end
    step(1'b0, 1'b1);
    check("mid rst hcount", if_b.hcount, 0);
    check("mid rst vcount", if_b.vcount, 0);
    check("mid rst hblnk", if_b.hblnk, 0);
    check("mid rst vblnk", if_b.vblnk, 0);
    check("mid rst hsync", if_b.hsync, 0);
    check("mid rst vsync", if_b.vsync, 0);
    check("mid rst frame_start", fs_b, 0);
    step(1'b1, 1'b1);
    check("post rst hcount", if_b.hcount, 1);
    check("post rst frame_start", fs_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
